// File: rtl/regfile_mp.sv
// Multi-port integer register file: two write ports, same-cycle write-to-read bypass,
// and one pending-write (busy) bit per register for the decode-stage scoreboard.
module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*$clog2(NREGS)-1:0] rd_addr,
    output logic [NUM_RD*XLEN-1:0]     rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [1:0]                 wr_en,
    input  logic [2*$clog2(NREGS)-1:0] wr_addr,
    input  logic [2*XLEN-1:0]          wr_data,
    input  logic                       issue_en,
    input  logic [$clog2(NREGS)-1:0]   issue_addr,
    input  logic                       flush
);

    localparam int unsigned AW     = $clog2(NREGS);
    localparam int unsigned NSLOTS = 1 << AW;

    // Per-address legality: inside NREGS and not the hardwired zero register.
    function automatic logic [NSLOTS-1:0] valid_mask();
        logic [NSLOTS-1:0] m;
        for (int unsigned i = 0; i < NSLOTS; i++) begin
            m[i] = (i < NREGS) && !((ZERO_REG != 0) && (i == 0));
        end
        return m;
    endfunction

    localparam logic [NSLOTS-1:0] VALID_MASK = valid_mask();

    logic [XLEN-1:0]   regs_q [NSLOTS];
    logic [XLEN-1:0]   regs_d [NSLOTS];
    logic [NSLOTS-1:0] busy_q;
    logic [NSLOTS-1:0] busy_d;

    logic [AW-1:0]     wr_addr_p [2];
    logic [XLEN-1:0]   wr_data_p [2];
    logic [1:0]        wr_ok;
    logic              issue_ok;

    // Unpack write ports and qualify them against the address map.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            wr_addr_p[p] = wr_addr[p*AW +: AW];
            wr_data_p[p] = wr_data[p*XLEN +: XLEN];
            wr_ok[p]     = wr_en[p] && VALID_MASK[wr_addr_p[p]];
        end
        issue_ok = issue_en && VALID_MASK[issue_addr];
    end

    // Port 1 is applied after port 0 so it wins a same-address collision;
    // issue is applied last so a new producer overrides a same-cycle writeback.
    always_comb begin
        regs_d = regs_q;
        busy_d = flush ? '0 : busy_q;
        for (int p = 0; p < 2; p++) begin
            if (wr_ok[p]) begin
                regs_d[wr_addr_p[p]] = wr_data_p[p];
                busy_d[wr_addr_p[p]] = 1'b0;
            end
        end
        if (issue_ok) begin
            busy_d[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOTS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Combinational read ports; reset forces zero so in-flight bypass data cannot leak out.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] data_c;
        logic            busy_c;

        assign ra = rd_addr[k*AW +: AW];

        always_comb begin
            data_c = regs_q[ra];
            busy_c = busy_q[ra];
            if (BYPASS != 0) begin
                for (int p = 0; p < 2; p++) begin
                    if (wr_ok[p] && (wr_addr_p[p] == ra)) begin
                        data_c = wr_data_p[p];
                        busy_c = 1'b0;
                    end
                end
            end
            if (!rst_n || !VALID_MASK[ra]) begin
                data_c = '0;
                busy_c = 1'b0;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = data_c;
        assign rd_busy[k]              = busy_c;
    end

endmodule
